// File: rtl/clock_works_if.sv
// clock_works_if
//   Carries the generated system clock and system reset from the clock/reset
//   root out to the rest of the SoC.
//   clk    divided system clock
//   rst_n  active-low system reset, released aligned to a falling edge of clk
//   master: driven by clock_works; slave: downstream consumers.
interface clock_works_if;
    logic clk;
    logic rst_n;

    modport master (output clk, output rst_n);
    modport slave  (input  clk, input  rst_n);
endinterface

// File: rtl/clock_works.sv
// clock_works
//   Clock/reset root of the SoC. Divides the board clock CLK by 2^(SLOW+1)
//   into a 50% duty system clock, and builds a clean active-low system reset
//   that asserts asynchronously with RESET and releases on the first falling
//   edge of the system clock after RESET has been synchronized.
// Ports
//   CLK    in   board clock, only clock domain of this block
//   RESET  in   board reset, asynchronous, active-low
//   sys    master modport: sys.clk (divided clock), sys.rst_n (system reset)
// Parameters
//   SLOW      divider exponent (>=0); sys.clk = CLK / 2^(SLOW+1)
//   SYNC_LEN  flops in the RESET release synchronizer (>=2)
module clock_works #(
    parameter int SLOW     = 22,
    parameter int SYNC_LEN = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    clock_works_if.master sys
);

    logic [SYNC_LEN-1:0] sync_q;
    logic                sync_ok;
    logic [SLOW:0]       cnt;
    logic                rst_q;

    // Release synchronizer: a RESET pulse of any width clears it at once,
    // release only propagates after SYNC_LEN CLK edges.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_LEN-1];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (!sync_ok) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // The counter only leaves zero after sync_ok, so the first all-ones value
    // marks the end of the first full clk period. Releasing here lands on a
    // clk falling edge, so downstream flops get half a period of setup and
    // have already seen one clk rising edge with rst_n low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rst_q <= 1'b0;
        end else if (sync_ok && (&cnt)) begin
            rst_q <= 1'b1;
        end
    end

    // Taken straight from flop outputs so neither output can glitch.
    assign sys.clk   = cnt[SLOW];
    assign sys.rst_n = rst_q;

endmodule

// File: tb/tb_clock_works.sv
module tb_clock_works;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    clock_works_if sys2 ();
    clock_works_if sys0 ();

    clock_works #(.SLOW(2), .SYNC_LEN(2)) dut2 (
        .CLK   (CLK),
        .RESET (RESET),
        .sys   (sys2.master)
    );

    clock_works #(.SLOW(0), .SYNC_LEN(2)) dut0 (
        .CLK   (CLK),
        .RESET (RESET),
        .sys   (sys0.master)
    );

    always #5 CLK = ~CLK;

    // Downstream clk-domain counter, cleared while rst_n is low.
    logic [7:0] dcnt;
    always_ff @(posedge sys2.clk or negedge sys2.rst_n) begin
        if (!sys2.rst_n) dcnt <= '0;
        else             dcnt <= dcnt + 8'd1;
    end

    int checks = 0;
    int errors = 0;
    int edge_n = 0;   // CLK rising edges since RESET was last released

    typedef struct {
        logic clk2;
        logic rst2;
        logic clk0;
        logic rst0;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        int   e;
        logic clk2;
        logic rst2;
    } vec_t;

    vec_t vecs[10];

    // Expected outputs after k CLK edges since release (k=0: in reset).
    // Counter sits at 0 until the synchronizer output is 1 before an edge,
    // which is from edge 3 on for a 2-flop chain.
    function automatic exp_t model(int k);
        exp_t r;
        int   c2;
        int   c0;
        c2     = (k <= 2) ? 0 : (k - 2) % 8;
        c0     = (k <= 2) ? 0 : (k - 2) % 2;
        r.clk2 = (c2 >= 4);
        r.rst2 = (k >= 10);
        r.clk0 = (c0 == 1);
        r.rst0 = (k >= 4);
        return r;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0b expected=%0b", name, edge_n, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: actual=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty at edge %0d: actual=0 entries expected>=1", edge_n);
        end else begin
            checks--;
            e = sb.pop_front();
            chk("clk_s2",   sys2.clk,   e.clk2);
            chk("rst_n_s2", sys2.rst_n, e.rst2);
            chk("clk_s0",   sys0.clk,   e.clk0);
            chk("rst_n_s0", sys0.rst_n, e.rst0);
        end
    endtask

    // One CLK edge while held in reset: everything must stay low.
    task automatic step_in_reset();
        @(posedge CLK);
        sb.push_back(model(0));
        #1;
        pop_compare();
    endtask

    task automatic step();
        @(posedge CLK);
        edge_n++;
        sb.push_back(model(edge_n));
        #1;
        pop_compare();
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET  = 1'b1;
        edge_n = 0;
    endtask

    int   rises;
    logic prev_clk;

    initial begin
        vecs[0] = '{e: 1,  clk2: 1'b0, rst2: 1'b0};
        vecs[1] = '{e: 2,  clk2: 1'b0, rst2: 1'b0};
        vecs[2] = '{e: 5,  clk2: 1'b0, rst2: 1'b0};
        vecs[3] = '{e: 6,  clk2: 1'b1, rst2: 1'b0};
        vecs[4] = '{e: 9,  clk2: 1'b1, rst2: 1'b0};
        vecs[5] = '{e: 10, clk2: 1'b0, rst2: 1'b1};
        vecs[6] = '{e: 13, clk2: 1'b0, rst2: 1'b1};
        vecs[7] = '{e: 14, clk2: 1'b1, rst2: 1'b1};
        vecs[8] = '{e: 17, clk2: 1'b1, rst2: 1'b1};
        vecs[9] = '{e: 18, clk2: 1'b0, rst2: 1'b1};

        // Power-up reset held for 5 CLK edges.
        #1 RESET = 1'b0;
        for (int i = 0; i < 5; i++) step_in_reset();

        // Release sequence against the hand-written table.
        release_reset();
        for (int i = 0; i < 10; i++) begin
            while (edge_n < vecs[i].e) begin
                step();
                if (edge_n == 13) chk_int("dcnt_before_first", int'(dcnt), 0);
            end
            chk("tbl_clk",   sys2.clk,   vecs[i].clk2);
            chk("tbl_rst_n", sys2.rst_n, vecs[i].rst2);
        end

        // Steady state out to 64 edges: count clk rises, follow downstream counter.
        rises    = 2;           // rises at edges 6 and 14 already passed
        prev_clk = sys2.clk;
        while (edge_n < 64) begin
            step();
            if (!prev_clk && sys2.clk) rises++;
            prev_clk = sys2.clk;
            if (edge_n >= 14 && ((edge_n - 14) % 8) == 0)
                chk_int("dcnt_inc", int'(dcnt), (edge_n - 14) / 8 + 1);
        end
        chk_int("clk_rises_64", rises, 8);

        // Mid-run reset while clk is high: outputs drop without a CLK edge.
        chk("pre_mid_clk_high", sys2.clk, 1'b1);
        #2 RESET = 1'b0;
        #1;
        chk("mid_clk_async",   sys2.clk,   1'b0);
        chk("mid_rst_n_async", sys2.rst_n, 1'b0);
        chk("mid_clk0_async",  sys0.clk,   1'b0);
        chk_int("mid_dcnt_clear", int'(dcnt), 0);
        step_in_reset();
        step_in_reset();
        release_reset();
        for (int i = 0; i < 12; i++) step();

        // Run on a little, then a 1 ns RESET glitch between CLK edges.
        while (edge_n < 20) step();
        chk("pre_glitch_rst_n", sys2.rst_n, 1'b1);
        #2 RESET = 1'b0;
        #1 RESET = 1'b1;
        edge_n = 0;
        chk("glitch_rst_n", sys2.rst_n, 1'b0);
        chk("glitch_clk",   sys2.clk,   1'b0);
        chk("glitch_rst0",  sys0.rst_n, 1'b0);
        for (int i = 0; i < 12; i++) step();
        chk_int("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
